// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - multi-cycle radix-2 DIV/DIVU sequencer with HI/LO registers
//
// Purpose: restoring shift-subtract divider. It produces one quotient bit per
// clock and writes quotient to lo and remainder to hi, in the MIPS style.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start, is_signed        launch a divide (sampled in IDLE only), DIV vs DIVU
//   dividend, divisor       operands, captured with start
//   flush                   aborts an in-flight divide
//   mthi_we, mtlo_we, wdata direct HI/LO writes
//   busy, done, div_by_zero status; done is a one-cycle pulse
//   hi, lo                  remainder / quotient registers
module div_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             flush,
   input  logic             mthi_we,
   input  logic             mtlo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int RW = WIDTH + 1;

   typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_lat, b_lat;   // operands as captured with start
   logic             sgn_lat;
   logic [WIDTH-1:0] quo;            // dividend bits shift out the top, quotient bits shift in
   logic [WIDTH-1:0] dvs;            // divisor magnitude
   logic [RW-1:0]    rem;            // partial remainder
   logic [CW-1:0]    cnt;
   logic             q_neg, r_neg;
   logic             dbz;

   logic [WIDTH-1:0] a_mag, b_mag;
   logic [RW:0]      trial;
   logic             trial_ge;

   assign a_mag    = (sgn_lat && a_lat[WIDTH-1]) ? -a_lat : a_lat;
   assign b_mag    = (sgn_lat && b_lat[WIDTH-1]) ? -b_lat : b_lat;
   assign trial    = {rem, quo[WIDTH-1]};
   assign trial_ge = (trial >= {2'b00, dvs});

   always_comb begin
      state_nxt = state;
      busy      = (state != S_IDLE);
      done      = (state == S_DONE);
      case (state)
         S_IDLE: if (start && !flush) state_nxt = S_PREP;
         S_PREP: begin
            if (flush)              state_nxt = S_IDLE;
            else if (b_mag == '0)   state_nxt = S_FIX;
            else                    state_nxt = S_ITER;
         end
         S_ITER: begin
            if (flush)              state_nxt = S_IDLE;
            else if (cnt == CW'(1)) state_nxt = S_FIX;
         end
         S_FIX:  state_nxt = flush ? S_IDLE : S_DONE;
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         a_lat   <= '0;
         b_lat   <= '0;
         sgn_lat <= 1'b0;
         quo     <= '0;
         dvs     <= '0;
         rem     <= '0;
         cnt     <= '0;
         q_neg   <= 1'b0;
         r_neg   <= 1'b0;
         dbz     <= 1'b0;
         hi      <= '0;
         lo      <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            S_IDLE: begin
               if (start && !flush) begin
                  a_lat   <= dividend;
                  b_lat   <= divisor;
                  sgn_lat <= is_signed;
               end
            end
            S_PREP: begin
               quo   <= a_mag;
               dvs   <= b_mag;
               rem   <= '0;
               cnt   <= CW'(WIDTH);
               q_neg <= sgn_lat & (a_lat[WIDTH-1] ^ b_lat[WIDTH-1]);
               r_neg <= sgn_lat & a_lat[WIDTH-1];
            end
            S_ITER: begin
               rem <= trial_ge ? RW'(trial - {2'b00, dvs}) : RW'(trial);
               quo <= {quo[WIDTH-2:0], trial_ge};
               cnt <= cnt - 1'b1;
            end
            S_DONE: dbz <= 1'b0;
            default: ;
         endcase

         if (mthi_we) hi <= wdata;
         if (mtlo_we) lo <= wdata;

         // Divide result is written after the direct writes so it wins on a shared edge.
         if (state == S_FIX && !flush) begin
            if (dvs == '0) begin
               lo  <= '1;
               hi  <= a_lat;
               dbz <= 1'b1;
            end else begin
               // most-negative / -1 needs no special case: magnitude quotient is
               // 2^(WIDTH-1) with a positive sign, which reads back as most-negative.
               lo <= q_neg ? -quo : quo;
               hi <= r_neg ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
            end
         end
      end
   end

   assign div_by_zero = dbz;

endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width.
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: start  input  1  request new divide; sampled only in IDLE.
REQ-005 SHALL have port: is_signed  input  1  1 = DIV semantics, 0 = DIVU semantics.
REQ-006 SHALL have port: dividend  input  WIDTH  numerator, captured with start.
REQ-007 SHALL have port: divisor  input  WIDTH  denominator, captured with start.
REQ-008 SHALL have port: flush  input  1  pipeline kill; aborts an in-flight divide.
REQ-009 SHALL have port: mthi_we / mtlo_we  input  1 each  direct HI / LO write strobes.
REQ-010 SHALL have port: wdata  input  WIDTH  data for mthi_we / mtlo_we.
REQ-011 SHALL have port: busy  output  1  high in every state except IDLE; pipeline stalls MFHI/MFLO on it.
REQ-012 SHALL have port: done  output  1  one-cycle pulse, new HI/LO valid.
REQ-013 SHALL have port: div_by_zero  output  1  valid with done; divisor was 0.
REQ-014 SHALL have port: hi / lo  output  WIDTH each  remainder / quotient registers.

Function
REQ-015 SHALL implement FSM IDLE, PREP, ITER, FIX, DONE; one transition per clock.
REQ-016 IDLE: start=1 and flush=0 SHALL latch operands and is_signed, go to PREP; otherwise stay.
REQ-017 PREP: SHALL form unsigned magnitudes (two's-complement negate of negative operand when is_signed), record quotient sign = sign(dividend) XOR sign(divisor) and remainder sign = sign(dividend), load iteration counter = WIDTH; divisor magnitude 0 -> FIX, else -> ITER.
REQ-018 ITER: SHALL perform one shift-subtract quotient bit per cycle, MSB first, partial remainder held at WIDTH+1 bits; counter decrements; counter reaching 0 -> FIX after exactly WIDTH ITER cycles.
REQ-019 FIX: SHALL negate quotient if quotient sign set and remainder if remainder sign set (signed only), write lo = quotient, hi = remainder, -> DONE.
REQ-020 Zero divisor: FIX SHALL write lo = all-ones, hi = latched dividend (unmodified), set div_by_zero.
REQ-021 Signed overflow (most-negative / -1): lo SHALL = most-negative value, hi = 0; no flag.
REQ-022 Quotient SHALL truncate toward zero; nonzero remainder SHALL carry dividend sign.
REQ-023 DONE: done=1 for this cycle only; unconditional -> IDLE; div_by_zero cleared on leaving DONE.
REQ-024 Latency: start sampled at edge k -> hi/lo updated and done high after edge k+WIDTH+2 (k+34 for WIDTH=32); zero divisor after edge k+2.
REQ-025 start while busy SHALL be ignored, not queued.
REQ-026 flush in PREP/ITER/FIX SHALL return to IDLE next edge, hi/lo unchanged, no done; flush in IDLE or DONE ignored; flush with start in IDLE: flush wins.
REQ-027 mthi_we/mtlo_we SHALL update hi/lo next edge in any state; FIX write on same edge takes priority.
REQ-028 Operand input changes after capture SHALL NOT affect the running divide.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0, counter=0.
REQ-030 Reset mid-operation SHALL abort without done; first start after release runs normally.

Verification
REQ-031 DIVU 100/7 -> lo=14, hi=2, done exactly once 34 edges after start edge, busy high 35 cycles.
REQ-032 DIV 0xFFFFFFF9 / 2 (-7/2) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
REQ-033 DIVU 5/0 -> lo=0xFFFFFFFF, hi=5, div_by_zero=1 with done 2 edges after start.
REQ-034 Start 100/7, flush on 10th ITER cycle -> busy low next cycle, no done, hi/lo keep prior values; second start during busy ignored.
REQ-035 mtlo_we wdata=0x1234 in IDLE -> lo=0x1234 next edge; mthi_we on FIX edge -> hi = divide remainder.
REQ-036 rst_n pulsed low mid-ITER -> all outputs 0 asynchronously; subsequent DIVU 9/3 -> lo=3, hi=0.
